addr_stream_reader: RTL and testbench

//  Downstream consumer of the 3-level address generator. Takes its address stream over valid/ready.

---
 rtl/addr_stream_reader.sv | 147 ++++++++++++++
 tb/tb_addr_stream_reader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/addr_stream_reader.sv
// Address-stream reader: accepts generator addresses, reads a 1-cycle RAM, buffers words in a FWFT FIFO.
// Define ADDR_STREAM_READER_BOUNDS_EN to replace out-of-range reads with zero words and flag err_o.
module addr_stream_reader #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_ADDR_W = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_i,
  input  logic                  addr_valid_i,
  input  logic [ADDR_W-1:0]     addr_i,
  output logic                  addr_ready_o,
  input  logic                  gen_done_i,
  output logic                  mem_en_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0]     mem_data_i,
  output logic                  data_valid_o,
  output logic [DATA_W-1:0]     data_o,
  input  logic                  data_ready_i,
  output logic                  done_o,
  output logic [31:0]           count_o,
  output logic                  err_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW+1:0] DepthV = (PtrW+2)'(FIFO_DEPTH);
  localparam logic [PtrW:0]   FullV  = (PtrW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]       cnt_q, cnt_d;
  logic                inflight_q, zero_q, done_q;
  logic [31:0]         count_q;
  logic [PtrW+1:0]     used;
  logic                accept, oob, wr_en, pop, empty, full;
  logic [DATA_W-1:0]   wdata;

  // Credit covers both buffered words and the read still in flight.
  assign used         = {1'b0, cnt_q} + {{(PtrW+1){1'b0}}, inflight_q};
  assign addr_ready_o = (state_q == StStream) && (used < DepthV);
  assign accept       = addr_valid_i && addr_ready_o;

`ifdef ADDR_STREAM_READER_BOUNDS_EN
  logic err_q;
  assign oob = (addr_i >> MEM_ADDR_W) != '0;
  always_ff @(posedge clk) begin
    if (rst || run_i) begin
      err_q <= 1'b0;
    end else if (accept && oob) begin
      err_q <= 1'b1;
    end
  end
  assign err_o = err_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i;
  assign oob   = 1'b0;
  assign err_o = 1'b0;
`endif

  assign mem_en_o   = accept && !oob;
  assign mem_addr_o = accept ? addr_i[MEM_ADDR_W-1:0] : '0;

  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == FullV);
  assign wr_en        = inflight_q;
  assign pop          = !empty && data_ready_i;
  assign data_valid_o = !empty;
  assign data_o       = empty ? '0 : fifo_mem[rd_ptr_q];
  assign wdata        = zero_q ? '0 : mem_data_i;
  assign done_o       = done_q;
  assign count_o      = count_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !pop) begin
      cnt_d = cnt_q + (PtrW+1)'(1);
    end else if (!wr_en && pop) begin
      cnt_d = cnt_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      zero_q     <= 1'b0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (run_i) begin
      // A read returning this cycle is dropped along with the buffered words.
      state_q    <= StStream;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      zero_q     <= 1'b0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= accept;
      zero_q     <= accept && oob;
      cnt_q      <= cnt_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        count_q  <= count_q + 32'd1;
      end
      case (state_q)
        StStream: begin
          if (gen_done_i) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // No accepts in DRAIN, so an empty next-cycle FIFO means nothing is left.
          if (cnt_d == '0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StIdle, StDone: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_en && full))
    else $error("fifo write while full");

endmodule

// File: tb/tb_addr_stream_reader.sv
// Scoreboard bench for addr_stream_reader: stimulus pushes expected words, a monitor pops on handshake.
module tb_addr_stream_reader;

`ifdef ADDR_STREAM_READER_BOUNDS_EN
  localparam bit Bounds = 1'b1;
`else
  localparam bit Bounds = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, run_i, addr_valid_i, gen_done_i, data_ready_i;
  logic [31:0] addr_i;
  logic        addr_ready_o, mem_en_o, data_valid_o, done_o, err_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_data_i = '0;
  logic [31:0] data_o, count_o;

  logic [31:0] ram [1024];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int first_pop_cyc = 0;
  int pops = 0;

  addr_stream_reader #(
    .ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .run_i(run_i),
    .addr_valid_i(addr_valid_i), .addr_i(addr_i), .addr_ready_o(addr_ready_o),
    .gen_done_i(gen_done_i), .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o),
    .mem_data_i(mem_data_i), .data_valid_o(data_valid_o), .data_o(data_o),
    .data_ready_i(data_ready_i), .done_o(done_o), .count_o(count_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_en_o) mem_data_i <= ram[mem_addr_o];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Monitor: every handshaken word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && !run_i && data_valid_o && data_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", data_o);
      end else begin
        chk("data", data_o, exp_q.pop_front());
      end
      if (pops == 0) first_pop_cyc = cyc;
      pops++;
      last_pop_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run();
    run_i = 1'b1;
    gen_done_i = 1'b0;
    exp_q.delete();
    pops = 0;
    tick();
    run_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic last);
    int n = 0;
    bit ok = 1'b0;
    bit hi;
    addr_valid_i = 1'b1;
    addr_i = a;
    hi = (a[31:10] != '0);
    while (n < 100 && !ok) begin
      @(negedge clk);
      if (addr_ready_o) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      fail("addr_accept");
    end else begin
      gen_done_i = last;
      chk("mem_en", {31'b0, mem_en_o}, {31'b0, !(Bounds && hi)});
      chk("mem_addr", {22'b0, mem_addr_o}, {22'b0, a[9:0]});
      exp_q.push_back((Bounds && hi) ? 32'h0 : ram[a[9:0]]);
      tick();
    end
    addr_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int exp_cnt);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o && n < 200);
    if (!done_o) begin
      fail("done");
    end else begin
      chk("done_delay", cyc, last_pop_cyc + 1);
      chk("count", count_o, exp_cnt);
      chk("sb_empty", exp_q.size(), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = i * 3;
    rst = 1'b1; run_i = 1'b0; addr_valid_i = 1'b0; addr_i = '0;
    gen_done_i = 1'b0; data_ready_i = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, addr_ready_o}, 0);
    chk("rst_valid", {31'b0, data_valid_o}, 0);
    chk("rst_done", {31'b0, done_o}, 0);
    chk("rst_count", count_o, 0);
    tick();

    // 1: eight back-to-back addresses
    do_run();
    for (int i = 0; i < 8; i++) send(i, i == 7);
    wait_done(8);
    chk("throughput", last_pop_cyc - first_pop_cyc, 7);

    // 2: consumer stall mid-stream
    do_run();
    fork
      begin
        for (int i = 0; i < 8; i++) send(10 + i, i == 7);
      end
      begin
        tick(); tick();
        data_ready_i = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        chk("bp_ready", {31'b0, addr_ready_o}, 0);
        chk("bp_valid", {31'b0, data_valid_o}, 1);
        @(posedge clk); #1;
        data_ready_i = 1'b1;
      end
    join
    wait_done(8);

    // 3: gen_done with the final address
    do_run();
    for (int i = 0; i < 6; i++) send(i, i == 5);
    chk("drain_not_done", {31'b0, done_o}, 0);
    wait_done(6);

    // 4: run while FIFO holds 3 words and a read is in flight
    do_run();
    data_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(100 + i, 1'b0);
    do_run();
    @(negedge clk);
    chk("rerun_valid", {31'b0, data_valid_o}, 0);
    chk("rerun_count", count_o, 0);
    chk("rerun_done", {31'b0, done_o}, 0);
    chk("rerun_ready", {31'b0, addr_ready_o}, 1);
    tick();
    data_ready_i = 1'b1;
    send(200, 1'b1);
    wait_done(1);

    // 5: address above the RAM range
    ram[0] = 32'h5A5A_0001;
    do_run();
    send(32'h400, 1'b1);
    wait_done(1);
    chk("err", {31'b0, err_o}, {31'b0, Bounds});
    repeat (3) tick();
    chk("err_held", {31'b0, err_o}, {31'b0, Bounds});

    // 6: reset mid-stream
    do_run();
    send(0, 1'b0); send(1, 1'b0); send(2, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("r6_ready", {31'b0, addr_ready_o}, 0);
    chk("r6_mem_en", {31'b0, mem_en_o}, 0);
    chk("r6_mem_addr", {22'b0, mem_addr_o}, 0);
    chk("r6_valid", {31'b0, data_valid_o}, 0);
    chk("r6_data", data_o, 0);
    chk("r6_done", {31'b0, done_o}, 0);
    chk("r6_count", count_o, 0);
    chk("r6_err", {31'b0, err_o}, 0);
    tick();
    addr_valid_i = 1'b1;
    addr_i = 32'd5;
    @(negedge clk);
    @(negedge clk);
    chk("idle_ready", {31'b0, addr_ready_o}, 0);
    chk("idle_mem_en", {31'b0, mem_en_o}, 0);
    tick();
    addr_valid_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
